btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 9 +
 rtl/btn_channel.sv | 91 +++++++++
 rtl/btn_conditioner.sv | 31 +++
 tb/tb_btn_conditioner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: repeat-FSM state type and default timing constants shared by the button conditioner
package btn_pkg;
    typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} rpt_state_t;
    localparam int DEF_N_BTN        = 4;
    localparam int DEF_DB_CYCLES    = 1_000_000;
    localparam int DEF_REPEAT_DELAY = 50_000_000;
    localparam int DEF_REPEAT_RATE  = 10_000_000;
    localparam int DEF_REPEAT_EN    = 1;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: 2-flop synchroniser, debouncer and auto-repeat FSM for one button
module btn_channel import btn_pkg::*; #(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int DBW = $clog2(DB_CYCLES);
    localparam int TW  = $clog2(REPEAT_DELAY);
    localparam logic [DBW-1:0] DB_MAX   = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  DLY_MAX  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0]  RATE_MAX = TW'(REPEAT_RATE - 1);

    logic [1:0]     r_sync;
    logic [DBW-1:0] r_db_cnt;
    logic [TW-1:0]  r_tmr, w_tmr_nxt;
    logic           r_level, r_press, r_release;
    rpt_state_t     r_state, w_state_nxt;
    logic           w_differ, w_qual, w_rise, w_fall, w_rpt;

    assign w_differ  = r_sync[1] != r_level;
    assign w_qual    = w_differ && r_db_cnt == DB_MAX;
    assign w_rise    = w_qual && !r_level;
    assign w_fall    = w_qual && r_level;
    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

    // A fall takes priority so a release landing on a repeat expiry emits no press
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + 1'b1;
        w_rpt       = 1'b0;
        if (w_fall) begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = '0;
        end else if (w_rise) begin
            w_state_nxt = REPEAT_EN != 0 ? HOLD_DELAY : IDLE;
            w_tmr_nxt   = '0;
        end else begin
            case (r_state)
                HOLD_DELAY: if (r_tmr == DLY_MAX) begin
                    w_rpt       = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = HOLD_REPEAT;
                end
                HOLD_REPEAT: if (r_tmr == RATE_MAX) begin
                    w_rpt     = 1'b1;
                    w_tmr_nxt = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_db_cnt  <= '0;
            r_tmr     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            r_db_cnt  <= (!w_differ || w_qual) ? '0 : r_db_cnt + 1'b1;
            r_tmr     <= w_tmr_nxt;
            r_level   <= r_level ^ w_qual;
            r_press   <= w_rise | w_rpt;
            r_release <= w_fall;
        end
    end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced buttons with press/release pulses and auto-repeat
module btn_conditioner import btn_pkg::*; #(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .REPEAT_EN   (REPEAT_EN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (btn_raw[i]),
            .o_level  (btn_level[i]),
            .o_press  (btn_press[i]),
            .o_release(btn_release[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table, directed and random checks of two conditioners (repeat on/off) against a run-length model
module tb_btn_conditioner;
    localparam int DB    = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = '0;
    logic [3:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;

    logic [3:0] m_s0, m_s1, m_lvl, m_p0, m_p1, m_rl;
    int         m_run [4];
    int         m_age [4];

    typedef struct {
        logic       rst;
        logic [3:0] raw;
        int         n;
        logic [3:0] lvl, prs, rel;
    } vec_t;
    vec_t tbl [14];

    always #5 clk = ~clk;

    btn_conditioner #(.N_BTN(4), .DB_CYCLES(DB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .REPEAT_EN(1)) dut0 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0)
    );
    btn_conditioner #(.N_BTN(4), .DB_CYCLES(DB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .REPEAT_EN(0)) dut1 (
        .clk(clk), .rst(rst), .btn_raw(btn_raw),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Level follows the synchronised input once it has differed for DB consecutive edges;
    // presses occur at hold age 0 and then at ages RDLY, RDLY+RRATE, ...
    task automatic model_step();
        if (rst) begin
            m_s0 = '0; m_s1 = '0; m_lvl = '0; m_p0 = '0; m_p1 = '0; m_rl = '0;
            for (int c = 0; c < 4; c++) begin
                m_run[c] = 0;
                m_age[c] = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_p0[c] = 1'b0; m_p1[c] = 1'b0; m_rl[c] = 1'b0;
                m_run[c] = (m_s1[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == DB) begin
                    m_run[c] = 0;
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) begin
                        m_p0[c] = 1'b1; m_p1[c] = 1'b1; m_age[c] = 0;
                    end else begin
                        m_rl[c] = 1'b1;
                    end
                end else if (m_lvl[c]) begin
                    m_age[c]++;
                    m_p0[c] = m_age[c] >= RDLY && (m_age[c] - RDLY) % RRATE == 0;
                end
                m_s1[c] = m_s0[c];
                m_s0[c] = btn_raw[c];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("model_lvl0", 32'(lvl0), 32'(m_lvl));
        chk("model_prs0", 32'(prs0), 32'(m_p0));
        chk("model_rel0", 32'(rel0), 32'(m_rl));
        chk("model_lvl1", 32'(lvl1), 32'(m_lvl));
        chk("model_prs1", 32'(prs1), 32'(m_p1));
        chk("model_rel1", 32'(rel1), 32'(m_rl));
    endtask

    initial begin
        int np0, nr0, np1, nr1;
        tbl[0]  = '{1'b1, 4'h0, 3,  4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 4'h0, 10, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{1'b0, 4'h1, 5,  4'h0, 4'h0, 4'h0};
        tbl[3]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0};
        tbl[4]  = '{1'b0, 4'h1, 1,  4'h1, 4'h0, 4'h0};
        tbl[5]  = '{1'b0, 4'h1, 18, 4'h1, 4'h0, 4'h0};
        tbl[6]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0};
        tbl[7]  = '{1'b0, 4'h1, 7,  4'h1, 4'h0, 4'h0};
        tbl[8]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0};
        tbl[9]  = '{1'b0, 4'h1, 8,  4'h1, 4'h1, 4'h0};
        tbl[10] = '{1'b0, 4'h1, 2,  4'h1, 4'h0, 4'h0};
        tbl[11] = '{1'b0, 4'h0, 5,  4'h1, 4'h0, 4'h0};
        tbl[12] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h1};
        tbl[13] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0};
        for (int k = 0; k < 14; k++) begin
            rst = tbl[k].rst;
            btn_raw = tbl[k].raw;
            for (int j = 0; j < tbl[k].n; j++) tick();
            chk($sformatf("tbl%0d_level", k), 32'(lvl0), 32'(tbl[k].lvl));
            chk($sformatf("tbl%0d_press", k), 32'(prs0), 32'(tbl[k].prs));
            chk($sformatf("tbl%0d_release", k), 32'(rel0), 32'(tbl[k].rel));
        end

        // Bounce on channel 1 never qualifies
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0) ? 4'h2 : 4'h0;
            for (int j = 0; j < 2; j++) begin
                tick();
                chk("bounce_quiet", 32'(lvl0 | prs0 | rel0), 32'h0);
            end
        end
        btn_raw = 4'h0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("bounce_quiet", 32'(lvl0 | prs0 | rel0), 32'h0);
        end

        // Simultaneous press on all channels
        btn_raw = 4'hF;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("simul_early_press", 32'(prs0), 32'h0);
        end
        tick();
        chk("simul_press", 32'(prs0), 32'hF);
        tick();
        chk("simul_press_one_cycle", 32'(prs0), 32'h0);

        // Reset in HOLD_REPEAT, button still held
        for (int j = 0; j < 23; j++) tick();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rst_outputs_zero", 32'({lvl0, prs0, rel0}), 32'h0);
        end
        rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("post_rst_early_press", 32'(prs0), 32'h0);
        end
        tick();
        chk("post_rst_press", 32'(prs0), 32'hF);
        btn_raw = 4'h0;
        for (int j = 0; j < 10; j++) tick();

        // 100-cycle hold: repeat-off gives one press; repeat-on loses the press at the fall edge
        np0 = 0; nr0 = 0; np1 = 0; nr1 = 0;
        btn_raw = 4'h1;
        for (int j = 0; j < 120; j++) begin
            if (j == 100) btn_raw = 4'h0;
            tick();
            np0 += int'(prs0[0]); nr0 += int'(rel0[0]);
            np1 += int'(prs1[0]); nr1 += int'(rel1[0]);
        end
        chk("noreps_press_count", 32'(np1), 32'd1);
        chk("noreps_release_count", 32'(nr1), 32'd1);
        chk("reps_press_count", 32'(np0), 32'd11);
        chk("reps_release_count", 32'(nr0), 32'd1);

        // Random stimulus against the model
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 29) == 0) btn_raw = 4'($urandom);
            else if ($urandom_range(0, 9) == 0) btn_raw ^= 4'(1 << $urandom_range(0, 3));
            rst = ($urandom_range(0, 399) == 0) ? 1'b1 : (rst && $urandom_range(0, 1) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
